// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_t         - receive FSM states
//   DATA_BITS          - payload bits per frame
//   OVERSAMPLE_DEFAULT - default baud_tick pulses per bit period
package uart_pkg;

  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk - destination clock
//   rst - asynchronous active-high reset; both flops reset to 1 (idle line)
//   d   - asynchronous input
//   q   - synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampled UART receiver with a one-entry output buffer.
//   clk, rst     - clock, asynchronous active-high reset
//   baud_tick    - sampling strobe at OVERSAMPLE x baud rate
//   rx           - asynchronous serial line, idles high
//   data_out     - received byte (LSB first on the line)
//   parity_bit   - received parity bit (0 when PARITY_EN=0)
//   data_valid   - buffer holds an unconsumed frame
//   data_ready   - consumer accepts the frame when data_valid is also high
//   framing_err  - one-clk pulse when a stop bit is sampled low
//   overrun_err  - one-clk pulse when a completed frame is dropped (buffer full)
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter logic        PARITY_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_bit,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 overrun_err
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  rx_state_t            state_q,      state_d;
  logic [TW-1:0]        tick_q,       tick_d;
  logic [BW-1:0]        bit_q,        bit_d;
  logic [DATA_BITS-1:0] shift_q,      shift_d;
  logic                 par_q,        par_d;
  logic [DATA_BITS-1:0] data_out_q,   data_out_d;
  logic                 parity_bit_q, parity_bit_d;
  logic                 data_valid_q, data_valid_d;
  logic                 framing_q,    framing_d;
  logic                 overrun_q,    overrun_d;

  logic sample;
  logic done;
  logic accept;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    parity_bit_d = parity_bit_q;
    data_valid_d = data_valid_q;
    framing_d    = 1'b0;
    overrun_d    = 1'b0;
    done         = 1'b0;
    accept       = data_valid_q & data_ready;

    // START samples mid-bit; later states sample one full bit period on.
    sample = (state_q == START) ? (tick_q == MID_CNT) : (tick_q == LAST_CNT);

    if (baud_tick) begin
      // Counter only runs once a frame is in progress.
      if (state_q != IDLE) begin
        tick_d = sample ? '0 : tick_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (sample) begin
            state_d = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (sample) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = PARITY_EN ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (sample) begin
            par_d   = rx_s;
            state_d = STOP;
          end
        end
        STOP: begin
          if (sample) begin
            state_d   = IDLE;
            done      = rx_s;
            framing_d = ~rx_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A handshake in the completion cycle frees the buffer for the new frame.
    if (done && (!data_valid_q || accept)) begin
      data_out_d   = shift_d;
      parity_bit_d = PARITY_EN ? par_q : 1'b0;
      data_valid_d = 1'b1;
    end else begin
      overrun_d = done;
      if (accept) begin
        data_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      parity_bit_q <= 1'b0;
      data_valid_q <= 1'b0;
      framing_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      parity_bit_q <= parity_bit_d;
      data_valid_q <= data_valid_d;
      framing_q    <= framing_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out    = data_out_q;
  assign parity_bit  = parity_bit_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: drives whole UART frames (directed and random) and
// compares the receiver outputs with a frame-level buffer model.
module tb_uart_rx_framer;

  localparam int unsigned OS = 16;  // baud_tick pulses per bit
  localparam int unsigned TD = 3;   // clk cycles between baud_ticks

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       parity_bit;
  logic       data_valid;
  logic       framing_err;
  logic       overrun_err;

  int total = 0;
  int bad   = 0;

  // Frame-level model: one-entry buffer plus expected error pulses.
  logic [7:0] ref_data;
  logic       ref_par;
  logic       ref_valid;
  logic       ref_ferr;
  logic       ref_ovr;
  int         ferr_seen = 0;
  int         ovr_seen  = 0;
  int         ferr_exp  = 0;
  int         ovr_exp   = 0;

  uart_rx_framer #(
    .OVERSAMPLE (OS),
    .PARITY_EN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .data_out    (data_out),
    .parity_bit  (parity_bit),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TD - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (framing_err === 1'b1) ferr_seen++;
    if (overrun_err === 1'b1) ovr_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_data"},  32'(data_out),    32'(ref_data));
    chk({tag, "_par"},   32'(parity_bit),  32'(ref_par));
    chk({tag, "_valid"}, 32'(data_valid),  32'(ref_valid));
    chk({tag, "_ferr"},  32'(framing_err), 32'(ref_ferr));
    chk({tag, "_ovr"},   32'(overrun_err), 32'(ref_ovr));
  endtask

  task automatic ref_reset();
    ref_data  = 8'h00;
    ref_par   = 1'b0;
    ref_valid = 1'b0;
    ref_ferr  = 1'b0;
    ref_ovr   = 1'b0;
  endtask

  task automatic ref_complete(input logic [7:0] d, input logic p, input logic stop, input logic rdy);
    ref_ferr = 1'b0;
    ref_ovr  = 1'b0;
    if (!stop) begin
      ref_ferr = 1'b1;
      ferr_exp++;
      if (rdy && ref_valid) ref_valid = 1'b0;
    end else if (!ref_valid || rdy) begin
      ref_data  = d;
      ref_par   = p;
      ref_valid = 1'b1;
    end else begin
      ref_ovr = 1'b1;
      ovr_exp++;
    end
  endtask

  // Returns at an active edge on which baud_tick was high.
  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    #1 rx = b;
    wait_ticks(OS);
  endtask

  // Full frame; rdy_stop pulses data_ready on the stop-sample edge only,
  // rdy_after drives data_ready for the following clk.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input logic rdy_stop, input logic rdy_after);
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    #1 rx = stop;
    wait_ticks(8);
    repeat (TD - 1) @(posedge clk);
    #1;
    chk("pre_stop_valid", 32'(data_valid), 32'(ref_valid));
    chk("pre_stop_ferr",  32'(framing_err), 32'h0);
    if (rdy_stop) data_ready = 1'b1;
    wait_ticks(1);  // stop-bit sample edge
    #1;
    data_ready = 1'b0;
    ref_complete(d, p, stop, rdy_stop);
    check_outputs("stop");
    rx = 1'b1;
    data_ready = rdy_after;
    @(posedge clk);
    #1;
    if (rdy_after && ref_valid) ref_valid = 1'b0;
    ref_ferr   = 1'b0;
    ref_ovr    = 1'b0;
    data_ready = 1'b0;
    check_outputs("after");
    wait_ticks(OS - 9);
  endtask

  initial begin
    rst        = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
    wait_ticks(4);

    // Good frame, consumer ready: one-clk valid pulse.
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    // Stop bit low: framing error, buffer untouched.
    send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Short low glitch on an idle line.
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(3);
    #1 rx = 1'b1;
    wait_ticks(2 * OS);
    #1;
    check_outputs("glitch");

    // Two frames without a consumer: second overruns.
    send_frame(8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
    // Completion coinciding with a handshake replaces the frame.
    send_frame(8'h34, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of data bit 4 of 0xFF.
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    #1 rx = 1'b1;
    wait_ticks(4);
    #1 rst = 1'b1;
    #1;
    ref_reset();
    check_outputs("midrst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_ticks(6 * OS);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random frames against the model.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       p;
      logic       stop;
      logic       rs;
      logic       ra;
      d    = 8'($urandom);
      p    = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      rs   = 1'($urandom_range(0, 1));
      ra   = 1'($urandom_range(0, 1));
      send_frame(d, p, stop, rs, ra);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("ferr_pulses", 32'(ferr_seen), 32'(ferr_exp));
    chk("ovr_pulses",  32'(ovr_seen),  32'(ovr_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter OVERSAMPLE, default 16: baud_tick pulses per bit period; legal values are even and at least 8.
REQ-002 Parameter PARITY_EN, default 1: 1 means the frame carries one parity bit after the data bits; 0 means it carries none.
REQ-003 clk  input  1  single clock for the block; every register uses its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 baud_tick  input  1  one-clk sampling strobe at OVERSAMPLE x baud rate.
REQ-006 rx  input  1  serial line, asynchronous to clk, idles high.
REQ-007 data_out  output  8  received byte, LSB first on the line; this feeds the parity checker data_in.
REQ-008 parity_bit  output  1  received parity bit; 0 when PARITY_EN=0.
REQ-009 data_valid  output  1  asserted while data_out and parity_bit hold an unconsumed frame.
REQ-010 data_ready  input  1  consumer accepts the frame in any cycle where data_valid and data_ready are both high.
REQ-011 framing_err  output  1  one-clk pulse when a stop bit is sampled low.
REQ-012 overrun_err  output  1  one-clk pulse when a completed frame is dropped because the buffer is still full.

Function
REQ-013 rx shall pass through a 2-FF synchronizer; the FSM shall see only the synchronized value rx_s.
REQ-014 The FSM shall have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 A tick counter shall run 0..OVERSAMPLE-1 and advance only on baud_tick; the bit sample point is count OVERSAMPLE/2-1 in START and count OVERSAMPLE-1 in every later state.
REQ-016 IDLE: on a baud_tick with rx_s=0, go to START and clear the tick counter.
REQ-017 START: at the mid-bit sample, rx_s=0 goes to DATA and rx_s=1 is a glitch that returns to IDLE with no output or error.
REQ-018 DATA: 8 samples, one per bit period, shifted in LSB first; a 3-bit bit counter wraps 7->0 on the exit to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
REQ-019 PARITY: one sample into the parity register, then go to STOP.
REQ-020 STOP: at the sample, return to IDLE; rx_s=1 completes the frame; rx_s=0 pulses framing_err the next clk and discards the frame.
REQ-021 Completion while data_valid=0 shall load data_out and parity_bit and set data_valid the next clk.
REQ-022 Completion while data_valid=1 shall keep the old frame, discard the new one, and pulse overrun_err the next clk.
REQ-023 If completion and a handshake (valid and ready) fall in the same clk, the new frame loads and data_valid stays 1; no overrun.
REQ-024 A handshake with no completion shall clear data_valid the next clk; data_out holds its last value.
REQ-025 Latency: data_valid rises exactly 1 clk after the stop-bit sample tick.
REQ-026 baud_tick ticks that arrive while the FSM is in IDLE shall not advance the tick counter.

Reset
REQ-027 rst shall force the FSM to IDLE and clear the tick and bit counters.
REQ-028 Reset values: data_out=8'h00, parity_bit=0, data_valid=0, framing_err=0, overrun_err=0, synchronizer flops=1.
REQ-029 rst asserted mid-frame shall abort the frame with no output pulse; after release the block waits for a new falling edge.

Structure
REQ-030 A shared package uart_pkg shall hold the state enum rx_state_t, DATA_BITS=8 and the OVERSAMPLE default.
REQ-031 One sub-module, sync_2ff, shall implement the synchronizer; the rest shall be flat in uart_rx_framer.

Verification
REQ-032 Frame 0x55 with parity 0, valid stop, data_ready=1 -> data_out=0x55, parity_bit=0, data_valid high for 1 clk, starting 1 clk after the stop sample.
REQ-033 Frame 0xA3 with parity 0 and stop=0 -> framing_err one-clk pulse, data_valid stays 0.
REQ-034 Low pulse of 3 ticks on idle line -> no data_valid, no error, FSM back in IDLE.
REQ-035 Two frames 0x12 then 0x34 with data_ready=0 -> data_out stays 0x12, overrun_err pulses once at the second stop sample.
REQ-036 data_ready raised in the same clk as the second completion -> data_out=0x34, data_valid stays high, no overrun.
REQ-037 rst asserted during DATA bit 4 of 0xFF -> all outputs at reset values; the next frame 0x0F is received correctly.
